pong_ball_engine: RTL
=====================

// Module: pong_ball_engine
// PURPOSE
//  Ball motion engine for the pong game. Sits directly downstream of the clock divider:
//  takes its divided game_clk as a level, edge-detects it into a one-cycle tick on clk.
//  On each tick, moves the ball, bounces it off walls and paddles, and flags missed balls.
//  Feeds the VGA renderer (ball position) and the score keeper (score pulses).
// PARAMETERS
//  H_RES      640  playfield width, pixels
//  V_RES      480  playfield height, pixels
//  BALL_SIZE  8    ball edge length, pixels (square)
//  PADDLE_H   64   paddle height, pixels
//  PADDLE_W   8    paddle width, pixels
//  PADDLE_X_L 16   left paddle left edge x; its hit face is PADDLE_X_L+PADDLE_W
//  PADDLE_X_R 616  right paddle left edge x (= its hit face)
//  STEP       2    pixels moved per tick on each axis
//  SERVE_WAIT 32   ticks spent in WAIT before the ball moves (>=1)
// PORTS
//  clk        in  1   system clock
//  rst        in  1   synchronous, active-high reset
//  game_clk   in  1   divided clock from clock divider; sampled as data, never used as a clock
//  serve      in  1   level; starts play from IDLE
//  paddle_l_y in  10  left paddle top y
//  paddle_r_y in  10  right paddle top y
//  ball_x     out 10  ball left x (registered)
//  ball_y     out 10  ball top y (registered)
//  dir_x      out 1   1 = moving right, 0 = left
//  dir_y      out 1   1 = moving down, 0 = up
//  score_l    out 1   one-clk pulse: right player missed
//  score_r    out 1   one-clk pulse: left player missed
//  busy       out 1   state != IDLE
// BEHAVIOUR
//  Tick: gclk_q <= game_clk every clk; tick = game_clk & ~gclk_q. Reset gclk_q = 1, so a
//   game_clk held high through reset gives no tick until its next rising edge. One tick per edge.
//  Reset values: state IDLE, ball_x=(H_RES-BALL_SIZE)/2, ball_y=(V_RES-BALL_SIZE)/2,
//   dir_x=1, dir_y=1, score_l=score_r=0, wait_cnt=0. Reset wins over all events, any state.
//  Latency: all updates happen on the clk edge where tick=1; outputs visible one cycle later.
//  States: IDLE(0) WAIT(1) MOVE(2) SCORE(3).
//   IDLE : ball centred; serve=1 on any clk -> WAIT, wait_cnt=SERVE_WAIT-1. No tick needed.
//   WAIT : on tick: wait_cnt==0 -> MOVE, else wait_cnt-1. Ball stays put.
//   MOVE : on tick, x and y evaluated independently and applied on the same edge:
//    right(dir_x=1): if ball_x+BALL_SIZE<=PADDLE_X_R and ball_x+BALL_SIZE+STEP>=PADDLE_X_R and
//     overlap_r -> ball_x=PADDLE_X_R-BALL_SIZE, dir_x=0; elif ball_x+BALL_SIZE+STEP>=H_RES ->
//     miss (score_l); else ball_x+=STEP.
//    left(dir_x=0), F=PADDLE_X_L+PADDLE_W: if ball_x>=F and ball_x<=F+STEP and overlap_l ->
//     ball_x=F, dir_x=1; elif ball_x<=STEP -> miss (score_r); else ball_x-=STEP.
//    overlap_p = (ball_y+BALL_SIZE > paddle_p_y) && (ball_y < paddle_p_y+PADDLE_H), using
//     ball_y before this tick's update. Paddle hit has priority over miss.
//    down: ball_y+BALL_SIZE+STEP>=V_RES -> ball_y=V_RES-BALL_SIZE, dir_y=0; else +STEP.
//    up:   ball_y<=STEP -> ball_y=0, dir_y=1; else -STEP.
//    miss: matching score pulse high for exactly the next clk cycle; state -> SCORE;
//     ball_x/ball_y hold (y still updates this tick).
//   SCORE: next clk (no tick needed): ball centred, dir_x toward player who missed
//     (score_l -> 1, score_r -> 0), dir_y unchanged, wait_cnt=SERVE_WAIT-1, -> WAIT.
//  serve ignored outside IDLE. Paddle inputs assumed stable within a clk; sampled only on tick.
//  Arithmetic done at 11 bits unsigned; no wrap; results always within 0..H_RES/V_RES-BALL_SIZE.
// TESTING (defaults unless noted)
//  1 rst 1 cycle -> ball (316,236), dir (1,1), IDLE, busy 0, scores 0; game_clk high at
//    release gives no tick until game_clk falls and rises again.
//  2 serve pulse, SERVE_WAIT=32 -> busy 1; MOVE after 32nd tick; next tick ball (318,238).
//  3 run from serve, paddles away from ball -> at ball_y=470 tick gives ball_y=472, dir_y=0;
//    next tick ball_y=470.
//  4 paddle_r_y tracks ball_y-20 -> ball_x=606 tick gives ball_x=608, dir_x=0, no score.
//  5 paddle_r_y=0, ball_y>=64 at crossing -> ball_x 630 tick: score_l high 1 clk, then ball
//    (316,y-centre 236), dir_x=1, WAIT; MOVE again after 32 ticks.
//  6 rst asserted mid-MOVE coincident with tick -> reset values next cycle, no score pulse;
//    game_clk held high 100 clk -> exactly one tick.

Source files
------------

// File: rtl/pong_ball_engine.sv
// Ball motion engine: turns the divided game clock into ticks and, on each tick,
// moves the ball, bounces it off walls and paddles and reports missed balls.
module pong_ball_engine #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_H   = 64,
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_X_L = 16,
    parameter int PADDLE_X_R = 616,
    parameter int STEP       = 2,
    parameter int SERVE_WAIT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_clk,
    input  logic       serve,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       score_l,
    output logic       score_r,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        MOVE  = 2'd2,
        SCORE = 2'd3
    } state_t;

    localparam int WW = $clog2(SERVE_WAIT + 1);

    localparam logic [9:0]    X_CENTRE  = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]    Y_CENTRE  = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [WW-1:0] WAIT_INIT = WW'(SERVE_WAIT - 1);

    localparam logic [10:0] HR   = 11'(H_RES);
    localparam logic [10:0] VR   = 11'(V_RES);
    localparam logic [10:0] BS   = 11'(BALL_SIZE);
    localparam logic [10:0] PH   = 11'(PADDLE_H);
    localparam logic [10:0] PXR  = 11'(PADDLE_X_R);
    localparam logic [10:0] FACE = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0] ST   = 11'(STEP);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          gclk_q;
    logic          tick;

    logic [10:0] bx, by, pl, pr;
    logic        overlap_l, overlap_r;
    logic [9:0]  nx, ny;
    logic        ndx, ndy;
    logic        miss_l, miss_r;

    // game_clk is data from the divider; only its rising edge matters.
    assign tick = game_clk & ~gclk_q;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign pl = {1'b0, paddle_l_y};
    assign pr = {1'b0, paddle_r_y};

    assign overlap_l = (by + BS > pl) && (by < pl + PH);
    assign overlap_r = (by + BS > pr) && (by < pr + PH);

    // Next position for one tick; x and y are resolved independently.
    always_comb begin
        nx     = ball_x;
        ny     = ball_y;
        ndx    = dir_x;
        ndy    = dir_y;
        miss_l = 1'b0;
        miss_r = 1'b0;

        if (dir_x) begin
            if ((bx + BS <= PXR) && (bx + BS + ST >= PXR) && overlap_r) begin
                nx  = 10'(PXR - BS);
                ndx = 1'b0;
            end else if (bx + BS + ST >= HR) begin
                miss_l = 1'b1;
            end else begin
                nx = 10'(bx + ST);
            end
        end else begin
            if ((bx >= FACE) && (bx <= FACE + ST) && overlap_l) begin
                nx  = 10'(FACE);
                ndx = 1'b1;
            end else if (bx <= ST) begin
                miss_r = 1'b1;
            end else begin
                nx = 10'(bx - ST);
            end
        end

        if (dir_y) begin
            if (by + BS + ST >= VR) begin
                ny  = 10'(VR - BS);
                ndy = 1'b0;
            end else begin
                ny = 10'(by + ST);
            end
        end else begin
            if (by <= ST) begin
                ny  = 10'd0;
                ndy = 1'b1;
            end else begin
                ny = 10'(by - ST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ball_x   <= X_CENTRE;
            ball_y   <= Y_CENTRE;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            score_l  <= 1'b0;
            score_r  <= 1'b0;
            wait_cnt <= '0;
            gclk_q   <= 1'b1;
        end else begin
            gclk_q  <= game_clk;
            score_l <= 1'b0;
            score_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        if (wait_cnt == '0) state <= MOVE;
                        else                wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                MOVE: begin
                    if (tick) begin
                        ball_y <= ny;
                        dir_y  <= ndy;
                        // A miss freezes x where it was; y still advances this tick.
                        if (miss_l || miss_r) begin
                            score_l <= miss_l;
                            score_r <= miss_r;
                            state   <= SCORE;
                        end else begin
                            ball_x <= nx;
                            dir_x  <= ndx;
                        end
                    end
                end
                SCORE: begin
                    // score_l is high here exactly when the right side missed.
                    ball_x   <= X_CENTRE;
                    ball_y   <= Y_CENTRE;
                    dir_x    <= score_l;
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
